// File: rtl/bo_2oper_if.sv
// Bus between the microprogrammed control unit and the bo_2oper datapath.
// The master drives the control word and operands.
// The slave returns the branch conditions and results.
interface bo_2oper_if #(
  parameter int N = 4
);
  logic [10:1]    y;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic [2:0]     x;
  logic [N-1:0]   rr;
  logic [2*N-1:0] product;
  logic [1:0]     rpr;

  modport master (
    output y, a, b,
    input  x, rr, product, rpr
  );

  modport slave (
    input  y, a, b,
    output x, rr, product, rpr
  );
endinterface

// File: rtl/bo_2oper.sv
// Operation block of the two-operand add/multiply processor.
// Each clock it executes the micro-operations selected by y[10:1]:
//   - ones'-complement add, or Booth add/subtract;
//   - operand load, shift, clear and result-flag capture.
// It returns the branch conditions x[2:0] to the control unit.
module bo_2oper #(
  parameter int N = 4
) (
  input logic        clk,
  input logic        set,
  bo_2oper_if.slave  bus
);

  logic [N-1:0] ra_r;
  logic [N-1:0] rb_r;
  logic         q_r;
  logic [N:0]   rr_r;
  logic         ovf_r;
  logic [1:0]   rpr_r;

  logic [N-1:0] op2_s;
  logic [N:0]   sum_c_s;
  logic [N-1:0] s_s;
  logic [N:0]   ra_ext_s;
  logic [N:0]   booth_s;
  logic [N:0]   adder_s;
  logic         add_ovf_s;

  // Result classification.
  // Overflow wins; both zero encodings (+0 and ones'-complement -0) count as zero.
  function automatic logic [1:0] rpr_flag(input logic ovf, input logic [N-1:0] r);
    logic [1:0] f;
    if (ovf) begin
      f = 2'b11;
    end else if ((r == {N{1'b0}}) || (r == {N{1'b1}})) begin
      f = 2'b00;
    end else if (r[N-1]) begin
      f = 2'b10;
    end else begin
      f = 2'b01;
    end
    return f;
  endfunction

  // Second adder operand: RA, its ones' complement, or zero.
  always_comb begin
    op2_s = {N{1'b0}};
    if (bus.y[4]) begin
      op2_s = ra_r;
    end else if (bus.y[5]) begin
      op2_s = ~ra_r;
    end else begin
      op2_s = {N{1'b0}};
    end
  end

  // Ones'-complement adder with end-around carry.
  // Booth adder works on the N+1-bit RR.
  always_comb begin
    sum_c_s  = {1'b0, rb_r} + {1'b0, op2_s};
    s_s      = sum_c_s[N-1:0] + {{(N-1){1'b0}}, sum_c_s[N]};
    ra_ext_s = {ra_r[N-1], ra_r};
    booth_s  = rr_r;
    if (bus.y[4]) begin
      booth_s = rr_r + ra_ext_s;
    end else if (bus.y[5]) begin
      booth_s = rr_r - ra_ext_s;
    end else begin
      booth_s = rr_r;
    end
    if (bus.y[9]) begin
      adder_s   = booth_s;
      add_ovf_s = 1'b0;
    end else begin
      adder_s   = {s_s[N-1], s_s};
      add_ovf_s = (rb_r[N-1] == op2_s[N-1]) & (s_s[N-1] != rb_r[N-1]);
    end
  end

  // Register file update.
  // Reset overrides every micro-operation.
  // The adder always sees the pre-edge RA, even when y1 loads RA in the same word.
  always_ff @(posedge clk) begin
    if (set) begin
      ra_r  <= {N{1'b0}};
      rb_r  <= {N{1'b0}};
      q_r   <= 1'b0;
      rr_r  <= {(N+1){1'b0}};
      ovf_r <= 1'b0;
      rpr_r <= 2'b00;
    end else begin
      if (bus.y[1]) begin
        ra_r <= bus.a;
      end
      if (bus.y[2]) begin
        rb_r <= bus.b;
        q_r  <= 1'b0;
      end else if (bus.y[3]) begin
        rb_r <= {rr_r[0], rb_r[N-1:1]};
        q_r  <= rb_r[0];
      end
      if (bus.y[7]) begin
        if (bus.y[8]) begin
          rr_r <= {(N+1){1'b0}};
        end else if (bus.y[6]) begin
          rr_r  <= adder_s;
          ovf_r <= add_ovf_s;
        end else if (bus.y[3]) begin
          rr_r <= {rr_r[N], rr_r[N:1]};
        end
      end
      if (bus.y[10]) begin
        rpr_r <= rpr_flag(ovf_r, rr_r[N-1:0]);
      end
    end
  end

  assign bus.x       = {&rr_r[N-1:0], q_r, rb_r[0]};
  assign bus.rr      = rr_r[N-1:0];
  assign bus.product = {rr_r[N-1:0], rb_r};
  assign bus.rpr     = rpr_r;

endmodule

// File: tb/tb_bo_2oper.sv
// Directed self-checking bench for bo_2oper with N=4.
module tb_bo_2oper;

  logic clk = 1'b0;
  logic set = 1'b1;
  int n_chk = 0;
  int n_fail = 0;

  bo_2oper_if #(.N(4)) bus ();

  bo_2oper #(.N(4)) dut (
    .clk (clk),
    .set (set),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one control word for one clock; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic [10:1] yv, input logic [3:0] av, input logic [3:0] bv);
    bus.y = yv;
    bus.a = av;
    bus.b = bv;
    @(posedge clk);
    #1;
    bus.y = 10'b0000000000;
  endtask

  // Run a Booth multiply.
  // The add/subtract word is chosen from the expected x[1:0] sequence, packed MSB first.
  task automatic booth(input string tag, input logic [3:0] av, input logic [3:0] bv,
                       input logic [7:0] xs, input logic [7:0] prod);
    logic [1:0] e;
    logic [10:1] w;
    step(10'b0011000111, av, bv);
    for (int i = 0; i < 4; i++) begin
      e = xs[7-2*i -: 2];
      chk($sformatf("%s_x%0d", tag, i), 32'(bus.x[1:0]), 32'(e));
      if (e == 2'b10) begin
        w = 10'b0101101000;
      end else if (e == 2'b01) begin
        w = 10'b0101110000;
      end else begin
        w = 10'b0101100000;
      end
      step(w, av, bv);
      step(10'b0001000100, av, bv);
    end
    chk({tag, "_product"}, 32'(bus.product), 32'(prod));
  endtask

  initial begin
    bus.y = 10'b0000000000;
    bus.a = 4'h0;
    bus.b = 4'h0;
    set   = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_x", 32'(bus.x), 32'h0);
    chk("rst_rr", 32'(bus.rr), 32'h0);
    chk("rst_product", 32'(bus.product), 32'h0);
    chk("rst_rpr", 32'(bus.rpr), 32'h0);
    set = 1'b0;

    // Load, then reset while an add is requested.
    step(10'b0011000111, 4'h5, 4'h6);
    chk("load_product", 32'(bus.product), 32'h06);
    set = 1'b1;
    step(10'b0001101000, 4'h5, 4'h6);
    set = 1'b0;
    chk("midrst_x", 32'(bus.x), 32'h0);
    chk("midrst_rr", 32'(bus.rr), 32'h0);
    chk("midrst_product", 32'(bus.product), 32'h0);
    chk("midrst_rpr", 32'(bus.rpr), 32'h0);
    // Adding after reset proves RA and RB were cleared.
    step(10'b0001101000, 4'h0, 4'h0);
    chk("postrst_add", 32'(bus.rr), 32'h0);

    // y1 together with y6: the adder uses the old RA.
    step(10'b0001101001, 4'h3, 4'h0);
    chk("same_word_old_ra", 32'(bus.rr), 32'h0);
    step(10'b0001101000, 4'h3, 4'h0);
    chk("same_word_new_ra", 32'(bus.rr), 32'h3);

    // Plain add: 3 + 2.
    step(10'b0011000111, 4'h3, 4'h2);
    step(10'b0001101000, 4'h3, 4'h2);
    chk("add_rr", 32'(bus.rr), 32'h5);
    chk("add_x2", 32'(bus.x[2]), 32'h0);
    step(10'b1000000000, 4'h3, 4'h2);
    chk("add_rpr", 32'(bus.rpr), 32'h1);

    // End-around carry: -1 + 3.
    step(10'b0011000111, 4'hE, 4'h3);
    step(10'b0001101000, 4'hE, 4'h3);
    chk("eac_rr", 32'(bus.rr), 32'h2);
    step(10'b1000000000, 4'hE, 4'h3);
    chk("eac_rpr", 32'(bus.rpr), 32'h1);

    // Negative zero: x[2] raised, then RR cleared before the flag capture.
    step(10'b0011000111, 4'hC, 4'h3);
    step(10'b0001101000, 4'hC, 4'h3);
    chk("negz_rr", 32'(bus.rr), 32'hF);
    chk("negz_x2", 32'(bus.x[2]), 32'h1);
    step(10'b0011000000, 4'hC, 4'h3);
    chk("negz_clr", 32'(bus.rr), 32'h0);
    step(10'b1000000000, 4'hC, 4'h3);
    chk("negz_rpr", 32'(bus.rpr), 32'h0);

    // Overflow: 5 + 4.
    step(10'b0011000111, 4'h5, 4'h4);
    step(10'b0001101000, 4'h5, 4'h4);
    chk("ovf_rr", 32'(bus.rr), 32'h9);
    step(10'b1000000000, 4'h5, 4'h4);
    chk("ovf_rpr", 32'(bus.rpr), 32'h3);

    // Booth multiplies: 3*2 and 3*(-2).
    booth("booth_pos", 4'h3, 4'h2, 8'b00_01_10_00, 8'h06);
    booth("booth_neg", 4'h3, 4'hE, 8'b00_01_11_11, 8'hFA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bo_2oper.md
Name: bo_2oper

Overview:
- Operation block (datapath) for the two-operand add/multiply processor, directly downstream of the microprogrammed control unit.
- Each clock it executes the micro-operations encoded on control word y[10:1]: operand load, ones'-complement add, Booth add/subtract, shift, clear, result-flag capture.
- It returns the logic conditions x[2:0] that the control unit branches on.

Parameters:
N, 4, operand width in bits (N >= 3)

Ports:
clk  in  1  clock, all registers update on rising edge
set  in  1  reset, synchronous, active-high
y  in  10 (y[10:1])  micro-operation control word
a  in  N  operand A, loaded into RA
b  in  N  operand B / multiplier, loaded into RB
x  out  3  logic conditions: x[2] = RR[N-1:0] all ones (negative zero); x[1] = q; x[0] = RB[0]
rr  out  N  RR[N-1:0], sum result / high half of product
product  out  2N  {RR[N-1:0], RB}
rpr  out  2  result flag register: 00 zero, 01 positive, 10 negative, 11 overflow

Behaviour:
- Internal registers:
  - RA: N bits.
  - RB: N bits.
  - q: 1 bit, Booth extension bit.
  - RR: N+1 bits, RR[N] is the guard/sign-extension bit.
  - ovf: 1 bit.
  - RPR: 2 bits.
- Reset: set=1 at a rising edge clears RA, RB, q, RR, ovf and RPR to 0, overriding every y bit.
  - Applies mid-operation too; the next cycle starts clean.
  - After reset: x=000, rr=0, product=0, rpr=00.
- Outputs are combinational from registers only; no combinational path from y to x.
- Micro-operations (all take effect at the edge where y is sampled):
  - y1: RA <= a.
  - y2: RB <= b; q <= 0. Has priority over y3 for RB/q.
  - y3 (without y2): q <= RB[0]; RB <= {RR[0], RB[N-1:1]}.
  - y7: RR write enable. Source priority: y8 > y6 > y3.
    - y8: RR <= 0.
    - y6: RR <= adder result.
    - y3: RR <= {RR[N], RR[N:1]}, arithmetic right shift.
    - y7 with none of y8/y6/y3: RR holds.
    - y6, y8 or y3 without y7: RR holds.
  - y10: RPR <= flag. Priority order:
    - ovf=1 -> 11.
    - RR[N-1:0] all zeros or all ones -> 00.
    - RR[N-1]=1 -> 10.
    - else -> 01.
  - Operand-2 select: y4 -> RA; y5 -> ~RA (y4 has priority); neither -> 0.
- Adder, y9=0 (addition mode, ones' complement, N bits):
  - s = RB + op2 + end-around carry.
  - RR <= {s[N-1], s}.
  - ovf <= (RB[N-1]==op2[N-1]) & (s[N-1]!=RB[N-1]), updated only when y7&y6.
- Adder, y9=1 (Booth mode, two's complement, N+1 bits):
  - RR <= RR + sext(RA) when y4; RR - sext(RA) when y5; RR when neither.
  - Truncated to N+1 bits; ovf <= 0 on write.
- Booth contract: the control unit adds on x[1:0]=10 and subtracts on x[1:0]=01, then shifts with y7|y3.
  - N such add/shift steps after load give the signed product on `product`.
- Simultaneous y1 and y6 in one word: adder uses the old RA.
- x[2] is used after a ones'-complement add; a value of 1 means the control unit must clear RR (y8|y7) before y10.

Test Plan:
- Reset: load a=5, b=6 (y=0011000111), then hold set=1 with y=0001101000 -> RR, RB, RA stay 0; x=000; rpr=00.
- Add: N=4, a=0011, b=0010, y=0011000111 then 0001101000 then 1000000000 -> rr=0101, x[2]=0, rpr=01.
- End-around carry: a=1110 (-1), b=0011, load then add -> rr=0010, then y10 -> rpr=01.
- Negative zero and overflow:
  - a=1100, b=0011 add -> rr=1111, x[2]=1; y=0011000000 -> rr=0000; y10 -> rpr=00.
  - a=0101, b=0100 add then y10 -> rr=1001, rpr=11.
- Booth multiply, a=0011, b=0010: load, then 4 steps of (add per x[1:0]: 10 -> 0101101000, 01 -> 0101110000, else 0101100000; then shift 0001000100).
  - x[1:0] sequence 00, 01, 10, 00.
  - product=0000_0110.
- Booth negative, a=0011, b=1110: same procedure -> x[1:0] sequence 00, 01, 11, 11; product=1111_1010 (-6).
